// File: rtl/uart_tx_scheduler_if.sv
// Request-side bundle for uart_tx_scheduler: per-requester valid/data in, one-hot ready out.
interface uart_tx_req_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (output req_valid, output req_data, input  req_ready);
    modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter in front of a single 8N1/8N2-style UART serialiser; every bit
// boundary is taken from an external baud_tick pulse.
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       baud_tick,
    uart_tx_req_if.slave               req,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       frame_done
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  frame_done_q, frame_done_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;

    logic                  found;
    logic [ID_W-1:0]       winner;
    logic                  accept;

    // First valid requester at or above ptr_q, wrapping past NUM_REQ-1.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req.req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign accept        = (state_q == IDLE) && found && !rst;
    assign req.req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        case (state_q)
            IDLE: begin
                // A tick coinciding with the accept is deliberately not used.
                if (accept) begin
                    shift_d = req.req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    grant_d = winner;
                    ptr_d   = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH-1)) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS-1)) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
            grant_q      <= '0;
            ptr_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign grant_id   = grant_q;
    assign frame_done = frame_done_q;
endmodule
